lsu_req_queue: RTL and testbench

- Parametrised load/store request unit between the EX-stage address computation and the SRAM-like data bus.
- Generalises the single-outstanding, 32-bit request path to DATA_W-wide lanes and up to OST_DEPTH in-flight requests.
- Tracks every accepted request in an in-order queue. Produces aligned, sign-/zero-extended load results, store completions and ALE exceptions in program order.
- Supports exception flush with silent draining of in-flight bus responses.

---
 rtl/lsu_pkg.sv | 67 ++++++
 rtl/lsu_ost_fifo.sv | 78 +++++++
 rtl/lsu_req_queue.sv | 105 ++++++++++
 tb/tb_lsu_req_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store request queue.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Per-request bookkeeping. The address is appended above these fields.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
        logic [2:0] ofs;
        logic       err;
    } ent_meta_t;

    localparam int unsigned ENT_META_W = $bits(ent_meta_t);

    // Low address bits that must be zero for an access of this size.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte strobes for a 2^size-byte access at byte offset ofs (8-lane max).
    function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] ofs);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << ofs;
    endfunction

    // Replicate LSB-justified store data across every lane of the bus.
    function automatic logic [63:0] lane_rep(input logic [1:0] size, input logic [63:0] d);
        case (size)
            SZ_B:    return {8{d[7:0]}};
            SZ_H:    return {4{d[15:0]}};
            SZ_W:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed bytes down and sign- or zero-extend them.
    function automatic logic [63:0] load_ext(input logic [1:0] size, input logic sgn,
                                             input logic [2:0] ofs, input logic [63:0] rdata);
        logic [63:0] sh;
        sh = rdata >> {ofs, 3'b000};
        case (size)
            SZ_B:    return {{56{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    return {{48{sgn & sh[15]}}, sh[15:0]};
            SZ_W:    return {{32{sgn & sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ost_fifo.sv
// In-order FIFO of outstanding requests with a parallel drop-flag vector.
module lsu_ost_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_drop_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state for storage, pointers, count and drop flags.
    // Flush marks every slot; a push always clears its own slot, so stale
    // marks on empty slots never leak into later entries.
    always_comb begin
        mem_d   = mem_q;
        drop_d  = drop_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            drop_d = '1;
        end
        if (push_i) begin
            mem_d[tail_q]  = push_data_i;
            drop_d[tail_q] = 1'b0;
            tail_d         = tail_q + 1'b1;
        end
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            drop_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign head_drop_o = drop_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/lsu_req_queue.sv
// Load/store request unit: issues aligned ops to the data bus, raises ALE for
// misaligned ones and retires everything in program order.
module lsu_req_queue
    import lsu_pkg::*;
#(
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned OST_DEPTH = 4,
    localparam int unsigned STRB_W    = DATA_W / 8,
    localparam int unsigned OFS_W     = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_we_i,
    input  logic [1:0]        in_size_i,
    input  logic              in_signed_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_wdata_i,
    input  logic              excep_flush_i,
    output logic              req_o,
    output logic              we_o,
    output logic [1:0]        size_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              resp_valid_o,
    output logic              resp_we_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_ale_o,
    output logic [ADDR_W-1:0] resp_badv_o,
    output logic              busy_o
);

    localparam int unsigned ENT_W = ADDR_W + ENT_META_W;

    logic [2:0]        in_ofs;
    logic              misaligned;
    logic              push, pop;
    logic              q_empty, q_full;
    ent_meta_t         push_meta, head_meta;
    logic [ENT_W-1:0]  head_data;
    logic [ADDR_W-1:0] head_addr;
    logic              head_drop;

    // Issue side: alignment check, bus request, strobes and lane replication.
    always_comb begin
        in_ofs     = 3'(in_addr_i[OFS_W-1:0]);
        misaligned = (in_ofs & size_mask(in_size_i)) != 3'b000;
        if (DATA_W == 32 && in_size_i == SZ_D) begin
            misaligned = 1'b1;
        end
        req_o   = in_valid_i & ~misaligned & ~q_full & ~excep_flush_i;
        we_o    = in_we_i;
        size_o  = in_size_i;
        addr_o  = in_addr_i;
        wstrb_o = in_we_i ? STRB_W'(strb_gen(in_size_i, in_ofs)) : '0;
        wdata_o = DATA_W'(lane_rep(in_size_i, 64'(in_wdata_i)));
        // An ALE op waits for an empty queue so its response stays in order.
        in_ready_o = misaligned ? (in_valid_i & q_empty & ~excep_flush_i)
                                : (req_o & addr_ok_i);
        push = in_ready_o;
        push_meta.we   = in_we_i;
        push_meta.size = in_size_i;
        push_meta.sgn  = in_signed_i;
        push_meta.ofs  = in_ofs;
        push_meta.err  = misaligned;
    end

    lsu_ost_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OST_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({in_addr_i, push_meta}),
        .pop_i       (pop),
        .flush_i     (excep_flush_i),
        .head_data_o (head_data),
        .head_drop_o (head_drop),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Retire side: head pops on data_ok, or straight away if it is an ALE.
    always_comb begin
        head_meta    = ent_meta_t'(head_data[ENT_META_W-1:0]);
        head_addr    = head_data[ENT_W-1:ENT_META_W];
        pop          = ~q_empty & (head_meta.err | data_ok_i);
        resp_valid_o = pop & ~head_drop;
        resp_we_o    = resp_valid_o & head_meta.we;
        resp_ale_o   = resp_valid_o & head_meta.err;
        resp_badv_o  = resp_ale_o ? head_addr : '0;
        resp_data_o  = (resp_valid_o & ~head_meta.we)
                     ? DATA_W'(load_ext(head_meta.size, head_meta.sgn, head_meta.ofs, 64'(rdata_i)))
                     : '0;
        busy_o       = ~q_empty;
    end

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed bench for lsu_req_queue: a 32-bit instance checked every cycle
// against a queue-based model, plus a 64-bit instance with literal checks.
module tb_lsu_req_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- 32-bit instance ----------------
    logic        s_valid = 0, s_we = 0, s_sgn = 0, s_flush = 0, s_aok = 0, s_dok = 0;
    logic [1:0]  s_size = 0;
    logic [31:0] s_addr = 0, s_wdata = 0, s_rdata = 0;
    logic        s_ready, s_req, s_bwe, s_rv, s_rwe, s_ale, s_busy;
    logic [1:0]  s_bsize;
    logic [3:0]  s_wstrb;
    logic [31:0] s_baddr, s_bwdata, s_rdat, s_badv;

    lsu_req_queue #(.DATA_W(32), .ADDR_W(32), .OST_DEPTH(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s_valid), .in_ready_o(s_ready), .in_we_i(s_we), .in_size_i(s_size),
        .in_signed_i(s_sgn), .in_addr_i(s_addr), .in_wdata_i(s_wdata), .excep_flush_i(s_flush),
        .req_o(s_req), .we_o(s_bwe), .size_o(s_bsize), .wstrb_o(s_wstrb), .addr_o(s_baddr),
        .wdata_o(s_bwdata), .addr_ok_i(s_aok), .data_ok_i(s_dok), .rdata_i(s_rdata),
        .resp_valid_o(s_rv), .resp_we_o(s_rwe), .resp_data_o(s_rdat), .resp_ale_o(s_ale),
        .resp_badv_o(s_badv), .busy_o(s_busy)
    );

    // ---------------- 64-bit instance ----------------
    logic        w_valid = 0, w_we = 0, w_sgn = 0, w_flush = 0, w_aok = 0, w_dok = 0;
    logic [1:0]  w_size = 0;
    logic [31:0] w_addr = 0;
    logic [63:0] w_wdata = 0, w_rdata = 0;
    logic        w_ready, w_req, w_bwe, w_rv, w_rwe, w_ale, w_busy;
    logic [1:0]  w_bsize;
    logic [7:0]  w_wstrb;
    logic [31:0] w_baddr, w_badv;
    logic [63:0] w_bwdata, w_rdat;

    lsu_req_queue #(.DATA_W(64), .ADDR_W(32), .OST_DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(w_valid), .in_ready_o(w_ready), .in_we_i(w_we), .in_size_i(w_size),
        .in_signed_i(w_sgn), .in_addr_i(w_addr), .in_wdata_i(w_wdata), .excep_flush_i(w_flush),
        .req_o(w_req), .we_o(w_bwe), .size_o(w_bsize), .wstrb_o(w_wstrb), .addr_o(w_baddr),
        .wdata_o(w_bwdata), .addr_ok_i(w_aok), .data_ok_i(w_dok), .rdata_i(w_rdata),
        .resp_valid_o(w_rv), .resp_we_o(w_rwe), .resp_data_o(w_rdat), .resp_ale_o(w_ale),
        .resp_badv_o(w_badv), .busy_o(w_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (32-bit) ----------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic        err;
        logic        drop;
    } mreq_t;

    mreq_t mq[$];

    function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = 1 << sz;
        return (sz != 2'd3) && ((a % n) == 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = 1 << sz;
        logic [31:0] m;
        m = ((32'd1 << n) - 32'd1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        int unsigned n = 1 << sz;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
        int unsigned n = 1 << sz;
        logic [31:0] sh, m;
        sh = rd >> (8 * (a % 4));
        if (n >= 4) return sh;
        m  = (32'd1 << (8 * n)) - 32'd1;
        sh = sh & m;
        if (sg && sh[8*n-1]) sh = sh | ~m;
        return sh;
    endfunction

    task automatic model_step();
        int unsigned cnt = mq.size();
        bit al  = m_aligned(s_size, s_addr);
        bit ereq = s_valid && al && (cnt < 4) && !s_flush;
        bit erdy = al ? (ereq && s_aok) : (s_valid && (cnt == 0) && !s_flush);
        bit pop = 0;
        bit erv = 0;
        mreq_t h;
        if (cnt != 0) begin
            h   = mq[0];
            pop = h.err || s_dok;
            erv = pop && !h.drop;
        end
        chk("m_req", s_req, ereq);
        chk("m_ready", s_ready, erdy);
        chk("m_busy", s_busy, cnt != 0);
        chk("m_resp_valid", s_rv, erv);
        if (ereq) begin
            chk("m_we", s_bwe, s_we);
            chk("m_size", s_bsize, s_size);
            chk("m_addr", s_baddr, s_addr);
            chk("m_wstrb", s_wstrb, s_we ? m_strb(s_size, s_addr) : 4'h0);
            chk("m_wdata", s_bwdata, m_wdata(s_size, s_wdata));
        end
        if (erv) begin
            chk("m_resp_we", s_rwe, h.we);
            chk("m_resp_ale", s_ale, h.err);
            chk("m_resp_badv", s_badv, h.err ? h.addr : 32'h0);
            if (h.we) chk("m_resp_data_st", s_rdat, 32'h0);
            else if (!h.err) chk("m_resp_data", s_rdat, m_ext(h.size, h.sgn, h.addr, s_rdata));
        end
        if (s_dok && cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL protocol: data_ok with %0d outstanding, required nonzero", cnt);
        end
        if (pop) void'(mq.pop_front());
        if (s_flush) foreach (mq[i]) mq[i].drop = 1'b1;
        if (erdy) mq.push_back('{we: s_we, size: s_size, sgn: s_sgn, addr: s_addr,
                                  err: !al, drop: 1'b0});
    endtask

    // One compare just before each rising edge, after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) model_step();
        end
    end

    // ---------------- drivers ----------------
    task automatic s_drv(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic fl);
        @(negedge clk);
        s_valid = v; s_we = we; s_size = sz; s_sgn = sg; s_addr = a; s_wdata = wd;
        s_aok = aok; s_dok = dok; s_rdata = rd; s_flush = fl;
    endtask

    task automatic s_idle(input logic dok, input logic [31:0] rd);
        s_drv(0, 0, 2'd0, 0, 32'h0, 32'h0, 0, dok, rd, 0);
    endtask

    task automatic w_drv(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [63:0] wd, input logic aok,
                         input logic dok, input logic [63:0] rd);
        @(negedge clk);
        w_valid = v; w_we = we; w_size = sz; w_sgn = sg; w_addr = a; w_wdata = wd;
        w_aok = aok; w_dok = dok; w_rdata = rd;
    endtask

    // Extra load table: size, signed, address, read data, expected result.
    logic [1:0]  t_sz  [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    logic        t_sg  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_ad  [4] = '{32'h3002, 32'h3000, 32'h3002, 32'h3004};
    logic [31:0] t_rd  [4] = '{32'h00C30000, 32'h00007FFF, 32'h9ABC0000, 32'hDEADBEEF};
    logic [31:0] t_exp [4] = '{32'h000000C3, 32'h00007FFF, 32'h00009ABC, 32'hDEADBEEF};

    initial begin
        #2;
        chk("rst_req32", s_req, 1'b0);
        chk("rst_busy32", s_busy, 1'b0);
        chk("rst_rv32", s_rv, 1'b0);
        chk("rst_busy64", w_busy, 1'b0);
        chk("rst_rv64", w_rv, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Store half at 0x1002.
        s_drv(1, 1, 2'd1, 0, 32'h1002, 32'h0000ABCD, 1, 0, 0, 0); #4;
        chk("st_req", s_req, 1'b1);
        chk("st_wstrb", s_wstrb, 4'b1100);
        chk("st_wdata", s_bwdata, 32'hABCDABCD);
        s_idle(1, 32'h0); #4;
        chk("st_resp_valid", s_rv, 1'b1);
        chk("st_resp_we", s_rwe, 1'b1);

        // Signed then unsigned byte load at 0x1003.
        s_drv(1, 0, 2'd0, 1, 32'h1003, 0, 1, 0, 0, 0);
        s_idle(1, 32'h80000000); #4;
        chk("lb_signed", s_rdat, 32'hFFFFFF80);
        s_drv(1, 0, 2'd0, 0, 32'h1003, 0, 1, 0, 0, 0);
        s_idle(1, 32'h80000000); #4;
        chk("lb_unsigned", s_rdat, 32'h00000080);

        // Misaligned word load with empty queue.
        s_drv(1, 0, 2'd2, 0, 32'h1001, 0, 0, 0, 0, 0); #4;
        chk("ale_req", s_req, 1'b0);
        chk("ale_ready", s_ready, 1'b1);
        s_idle(0, 0); #4;
        chk("ale_flag", s_ale, 1'b1);
        chk("ale_badv", s_badv, 32'h1001);

        // Misaligned op waits behind an outstanding load.
        s_drv(1, 0, 2'd2, 0, 32'h1000, 0, 1, 0, 0, 0);
        s_drv(1, 0, 2'd2, 0, 32'h1001, 0, 0, 0, 0, 0); #4;
        chk("ale_wait0", s_ready, 1'b0);
        s_drv(1, 0, 2'd2, 0, 32'h1001, 0, 0, 1, 32'h11223344, 0); #4;
        chk("ale_wait1", s_ready, 1'b0);
        s_drv(1, 0, 2'd2, 0, 32'h1001, 0, 0, 0, 0, 0); #4;
        chk("ale_go", s_ready, 1'b1);
        s_idle(0, 0);

        // Fill the queue, then a fifth load.
        for (int i = 0; i < 4; i++) s_drv(1, 0, 2'd2, 0, 32'h100 + 4 * i, 0, 1, 0, 0, 0);
        s_drv(1, 0, 2'd2, 0, 32'h110, 0, 1, 0, 0, 0); #4;
        chk("full_req", s_req, 1'b0);
        chk("full_ready", s_ready, 1'b0);
        s_drv(1, 0, 2'd2, 0, 32'h110, 0, 1, 1, 32'hA0, 0); #4;
        chk("full_pop_req", s_req, 1'b0);
        chk("full_pop_data", s_rdat, 32'hA0);
        s_drv(1, 0, 2'd2, 0, 32'h110, 0, 1, 1, 32'hA1, 0); #4;
        chk("fifth_req", s_req, 1'b1);
        chk("fifth_ready", s_ready, 1'b1);
        for (int i = 2; i < 5; i++) s_idle(1, 32'hA0 + i);

        // Flush with three loads in flight.
        s_drv(1, 0, 2'd1, 1, 32'h202, 0, 1, 0, 0, 0);
        s_drv(1, 0, 2'd0, 0, 32'h301, 0, 1, 0, 0, 0);
        s_drv(1, 0, 2'd2, 0, 32'h400, 0, 1, 0, 0, 0);
        s_drv(0, 0, 2'd0, 0, 32'h0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            s_idle(1, 32'hFFFFFFFF); #4;
            chk("flush_drop", s_rv, 1'b0);
        end
        s_drv(1, 0, 2'd1, 1, 32'h206, 0, 1, 0, 0, 0);
        s_idle(1, 32'h80010000); #4;
        chk("post_flush_valid", s_rv, 1'b1);
        chk("post_flush_data", s_rdat, 32'hFFFF8001);

        // Assorted loads.
        for (int i = 0; i < 4; i++) begin
            s_drv(1, 0, t_sz[i], t_sg[i], t_ad[i], 0, 1, 0, 0, 0);
            s_idle(1, t_rd[i]); #4;
            chk("tbl_data", s_rdat, 64'(t_exp[i]));
        end

        // Dword on a 32-bit bus is always an ALE.
        s_drv(1, 0, 2'd3, 0, 32'h3000, 0, 1, 0, 0, 0); #4;
        chk("d32_req", s_req, 1'b0);
        s_idle(0, 0); #4;
        chk("d32_ale", s_ale, 1'b1);
        s_idle(0, 0);

        // 64-bit instance.
        w_drv(1, 0, 2'd3, 0, 32'h2008, 0, 1, 0, 0); #4;
        chk("w_req", w_req, 1'b1);
        chk("w_wstrb_ld", w_wstrb, 8'h00);
        w_drv(0, 0, 2'd0, 0, 0, 0, 0, 1, 64'h0123456789ABCDEF); #4;
        chk("w_rv", w_rv, 1'b1);
        chk("w_data", w_rdat, 64'h0123456789ABCDEF);
        w_drv(1, 0, 2'd3, 0, 32'h2004, 0, 1, 0, 0); #4;
        chk("w_ale_req", w_req, 1'b0);
        w_drv(0, 0, 2'd0, 0, 0, 0, 0, 0, 0); #4;
        chk("w_ale", w_ale, 1'b1);
        chk("w_badv", w_badv, 32'h2004);
        w_drv(1, 1, 2'd2, 0, 32'h200C, 64'hCAFEF00D, 1, 0, 0); #4;
        chk("w_wstrb_st", w_wstrb, 8'hF0);
        chk("w_wdata", w_bwdata, 64'hCAFEF00DCAFEF00D);
        w_drv(0, 0, 2'd0, 0, 0, 0, 0, 1, 64'h5555); #4;
        chk("w_st_we", w_rwe, 1'b1);
        chk("w_st_data", w_rdat, 64'h0);
        w_drv(1, 0, 2'd0, 1, 32'h2007, 0, 1, 0, 0);
        w_drv(0, 0, 2'd0, 0, 0, 0, 0, 1, 64'h8000000000000000); #4;
        chk("w_lb_signed", w_rdat, 64'hFFFFFFFFFFFFFF80);
        w_drv(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
